sha_compress_engine: RTL and testbench

- Iterative SHA-2 compression engine that processes one 512/1024-bit message block per transaction against an 8-word chaining value.
- Executes one round per clock using an internal 16-word message-schedule shift register.
- Produces the feed-forward-added chaining value for the next block or the final digest.
- Parametrised over SHA-256 (32-bit) and SHA-512 (64-bit) word widths.
- Sits between the padding/block-assembly logic and the digest output register.
- Round constants come from an external K ROM.

---
 rtl/sha_pkg.sv | 25 ++
 rtl/sha_round_func.sv | 41 ++++
 rtl/sha_compress_engine.sv | 123 ++++++++++++
 tb/tb_sha_compress_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-2 definitions: FSM encoding, rotate/shift amounts for both word widths,
// and the standard initial hash values.
package sha_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFinal, StDone} state_e;

  // Order: Sigma0 x3, Sigma1 x3, sigma0 rot/rot/shr, sigma1 rot/rot/shr
  localparam int unsigned Rot32 [12] = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};
  localparam int unsigned Rot64 [12] = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};

  function automatic int unsigned rot_const(input int unsigned word_w, input logic [3:0] idx);
    return (word_w == 64) ? Rot64[idx] : Rot32[idx];
  endfunction

  localparam logic [255:0] Iv256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] Iv512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

endpackage

// File: rtl/sha_round_func.sv
// Combinational SHA-2 round: Sigma/Ch/Maj, T1/T2 and the rotated working variables.
module sha_round_func
  import sha_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [7:0][WORD_W-1:0] work_i,
  input  logic [WORD_W-1:0]      k_i,
  input  logic [WORD_W-1:0]      w_i,
  output logic [WORD_W-1:0]      t1_o,
  output logic [WORD_W-1:0]      t2_o,
  output logic [7:0][WORD_W-1:0] work_o
);

  localparam int unsigned S0a = rot_const(WORD_W, 4'd0);
  localparam int unsigned S0b = rot_const(WORD_W, 4'd1);
  localparam int unsigned S0c = rot_const(WORD_W, 4'd2);
  localparam int unsigned S1a = rot_const(WORD_W, 4'd3);
  localparam int unsigned S1b = rot_const(WORD_W, 4'd4);
  localparam int unsigned S1c = rot_const(WORD_W, 4'd5);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
  logic [WORD_W-1:0] big_s0, big_s1, ch, maj;

  // work_i[7] is A, work_i[0] is H
  always_comb begin
    {a, b, c, d, e, f, g, h} = work_i;
    big_s0 = rotr(a, S0a) ^ rotr(a, S0b) ^ rotr(a, S0c);
    big_s1 = rotr(e, S1a) ^ rotr(e, S1b) ^ rotr(e, S1c);
    ch     = (e & f) ^ (~e & g);
    maj    = (a & b) ^ (a & c) ^ (b & c);
    t1_o   = h + big_s1 + ch + k_i + w_i;
    t2_o   = big_s0 + maj;
    work_o = {t1_o + t2_o, a, b, c, d + t1_o, e, f, g};
  end

endmodule

// File: rtl/sha_compress_engine.sv
// Iterative SHA-256/SHA-512 compression: one round per clock, rolling 16-word schedule,
// feed-forward addition of the saved chaining value on completion.
module sha_compress_engine
  import sha_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*WORD_W-1:0]   in_block,
  input  logic [8*WORD_W-1:0]    in_hash,
  output logic [6:0]             k_idx,
  input  logic [WORD_W-1:0]      k_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*WORD_W-1:0]    out_hash
);

  if (WORD_W != 32 && WORD_W != 64) begin : gen_bad_width
    $error("sha_compress_engine: WORD_W must be 32 or 64");
  end

  localparam int unsigned NR        = (WORD_W == 32) ? 64 : 80;
  localparam logic [6:0]  LastRound = 7'(NR - 1);

  localparam int unsigned R0a = rot_const(WORD_W, 4'd6);
  localparam int unsigned R0b = rot_const(WORD_W, 4'd7);
  localparam int unsigned R0s = rot_const(WORD_W, 4'd8);
  localparam int unsigned R1a = rot_const(WORD_W, 4'd9);
  localparam int unsigned R1b = rot_const(WORD_W, 4'd10);
  localparam int unsigned R1s = rot_const(WORD_W, 4'd11);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  state_e                 state_q, state_d;
  logic [6:0]             round_q, round_d;
  logic [7:0][WORD_W-1:0] work_q, work_d, saved_q, saved_d, out_hash_q, out_hash_d;
  logic [15:0][WORD_W-1:0] sched_q, sched_d;
  logic [7:0][WORD_W-1:0] round_work;
  logic [WORD_W-1:0]      t1, t2, w_next;

  sha_round_func #(
    .WORD_W (WORD_W)
  ) u_round (
    .work_i (work_q),
    .k_i    (k_word),
    .w_i    (sched_q[15]),
    .t1_o   (t1),
    .t2_o   (t2),
    .work_o (round_work)
  );

  // sched_q[15] holds W_t; the word appended at [0] is W_{t+16}
  assign w_next = (rotr(sched_q[1], R1a) ^ rotr(sched_q[1], R1b) ^ (sched_q[1] >> R1s))
                + sched_q[6]
                + (rotr(sched_q[14], R0a) ^ rotr(sched_q[14], R0b) ^ (sched_q[14] >> R0s))
                + sched_q[15];

  assign out_hash = out_hash_q;

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    work_d     = work_q;
    saved_d    = saved_q;
    sched_d    = sched_q;
    out_hash_d = out_hash_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    k_idx      = 7'd0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sched_d = in_block;
          work_d  = in_hash;
          saved_d = in_hash;
          round_d = 7'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        k_idx   = round_q;
        work_d  = round_work;
        sched_d = {sched_q[14:0], w_next};
        if (round_q == LastRound) state_d = StFinal;
        else round_d = round_q + 7'd1;
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) out_hash_d[i] = saved_q[i] + work_q[i];
        state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      round_q    <= 7'd0;
      work_q     <= '0;
      saved_q    <= '0;
      sched_q    <= '0;
      out_hash_q <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      work_q     <= work_d;
      saved_q    <= saved_d;
      sched_q    <= sched_d;
      out_hash_q <= out_hash_d;
    end
  end

endmodule

// File: tb/tb_sha_compress_engine.sv
// Directed bench for both word widths with a digest scoreboard and an external K ROM model.
module tb_sha_compress_engine;
  import sha_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          iv32, ir32, ov32, or32;
  logic [511:0]  blk32;
  logic [255:0]  hin32, oh32;
  logic [6:0]    kidx32;
  logic [31:0]   kw32;
  logic          iv64, ir64, ov64, or64;
  logic [1023:0] blk64;
  logic [511:0]  hin64, oh64;
  logic [6:0]    kidx64;
  logic [63:0]   kw64;

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // SHA-256 constants are the upper halves of the SHA-512 ones
  assign kw32 = K512[kidx32][63:32];
  assign kw64 = K512[kidx64];

  localparam logic [511:0]  Abc256Blk   = {32'h61626380, 448'b0, 32'h00000018};
  localparam logic [511:0]  Empty256Blk = {32'h80000000, 480'b0};
  localparam logic [511:0]  Probe256Blk = {32'h02000000, 480'b0};
  localparam logic [1023:0] Abc512Blk   = {64'h6162638000000000, 896'b0, 64'h18};
  localparam logic [255:0]  Abc256Exp =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0]  Empty256Exp =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0]  Abc512Exp = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
  };

  sha_compress_engine #(.WORD_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_block(blk32), .in_hash(hin32),
    .k_idx(kidx32), .k_word(kw32), .out_valid(ov32), .out_ready(or32), .out_hash(oh32)
  );

  sha_compress_engine #(.WORD_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_block(blk64), .in_hash(hin64),
    .k_idx(kidx64), .k_word(kw64), .out_valid(ov64), .out_ready(or64), .out_hash(oh64)
  );

  int n_assert, n_fail;
  logic [511:0] sb [$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Offer one block in IDLE; returns #1 after the accept edge.
  task automatic accept(input bit m64, input logic [1023:0] blk, input logic [511:0] h,
                        input string tag);
    @(negedge clk);
    chk({tag, " in_ready"}, m64 ? ir64 : ir32, 1);
    if (m64) begin
      blk64 = blk; hin64 = h; iv64 = 1'b1;
    end else begin
      blk32 = blk[511:0]; hin32 = h[255:0]; iv32 = 1'b1;
    end
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    iv64 = 1'b0;
  endtask

  // Follow the run from the accept edge to the output handshake.
  task automatic finish_block(input bit m64, input int hold, input bit early, input string tag);
    int edges, kerr, nr;
    bit seen;
    logic [511:0] expd;
    nr = m64 ? 80 : 64;
    edges = 0; kerr = 0; seen = 1'b0;
    if (early) begin
      if (m64) or64 = 1'b1; else or32 = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m64 ? ov64 : ov32) begin
        seen = 1'b1;
        break;
      end
      if ((m64 ? kidx64 : kidx32) != ((edges < nr) ? edges[6:0] : 7'd0)) kerr++;
      @(posedge clk);
      edges++;
    end
    chk({tag, " out_valid seen"}, seen, 1);
    chk({tag, " k_idx sequence errors"}, kerr, 0);
    // out_valid first captured by the consumer on edge NR+2 after the accept edge
    chk({tag, " latency edges"}, edges + 1, nr + 2);
    chk({tag, " scoreboard entry"}, sb.size() > 0, 1);
    expd = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int c = 0; c < hold; c++) begin
      chk({tag, " held valid"}, m64 ? ov64 : ov32, 1);
      chk({tag, " held hash"}, m64 ? oh64 : {256'b0, oh32}, expd);
      if (m64) begin
        blk64 = {32{$urandom}}; iv64 = 1'b1;
      end else begin
        blk32 = {16{$urandom}}; iv32 = 1'b1;
      end
      @(negedge clk);
    end
    iv32 = 1'b0;
    iv64 = 1'b0;
    chk({tag, " digest"}, m64 ? oh64 : {256'b0, oh32}, expd);
    if (m64) or64 = 1'b1; else or32 = 1'b1;
    @(posedge clk);
    #1;
    or32 = 1'b0;
    or64 = 1'b0;
    @(negedge clk);
    chk({tag, " valid dropped"}, m64 ? ov64 : ov32, 0);
    chk({tag, " back to idle"}, m64 ? ir64 : ir32, 1);
  endtask

  initial begin
    int vcount;
    n_assert = 0; n_fail = 0;
    iv32 = 0; iv64 = 0; or32 = 0; or64 = 0;
    blk32 = '0; blk64 = '0; hin32 = '0; hin64 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready32", ir32, 1);
    chk("reset out_valid32", ov32, 0);
    chk("reset out_hash32", oh32, 0);
    chk("reset k_idx32", kidx32, 0);
    chk("reset in_ready64", ir64, 1);
    chk("reset out_valid64", ov64, 0);
    chk("reset out_hash64", oh64, 0);

    accept(1'b0, {512'b0, Abc256Blk}, {256'b0, Iv256}, "abc256");
    sb.push_back({256'b0, Abc256Exp});
    finish_block(1'b0, 0, 1'b0, "abc256");

    accept(1'b0, {512'b0, Probe256Blk}, {256'b0, Iv256}, "probe");
    @(negedge clk);
    chk("probe T1", u_dut32.u_round.t1_o, 32'hf577ed68);
    @(negedge clk);
    chk("probe E after edge 1", u_dut32.work_q[3], 32'h9ac7e2a2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("probe abort idle", ir32, 1);

    accept(1'b1, Abc512Blk, Iv512, "abc512");
    sb.push_back(Abc512Exp);
    finish_block(1'b1, 0, 1'b0, "abc512");

    accept(1'b0, {512'b0, Empty256Blk}, {256'b0, Iv256}, "empty256");
    sb.push_back({256'b0, Empty256Exp});
    finish_block(1'b0, 10, 1'b0, "empty256");

    accept(1'b0, {512'b0, Abc256Blk}, {256'b0, Iv256}, "rst20");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst20 k_idx before reset", kidx32, 20);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst20 in_ready", ir32, 1);
    chk("rst20 out_valid", ov32, 0);
    chk("rst20 k_idx", kidx32, 0);
    vcount = 0;
    repeat (80) begin
      @(negedge clk);
      if (ov32) vcount++;
    end
    chk("rst20 no out_valid pulse", vcount, 0);

    // out_ready held high from the start: ignored until DONE, then a one-cycle handshake
    accept(1'b0, {512'b0, Abc256Blk}, {256'b0, Iv256}, "abc256 after reset");
    sb.push_back({256'b0, Abc256Exp});
    finish_block(1'b0, 0, 1'b1, "abc256 after reset");

    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
